// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, FSM state encoding and operand-pair payload for
// the booth job sequencer and its operand FIFO.
package booth_pkg;

  localparam int unsigned OP_W   = 4;  // operand width (two's complement)
  localparam int unsigned PROD_W = 9;  // product width returned by the multiplier

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  // One queued job: multiplicand in the upper half, multiplier in the lower half.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

  // A product is trivially zero when either operand is zero.
  function automatic logic is_zero_job(op_pair_t p);
    return (p.a == '0) || (p.b == '0);
  endfunction

endpackage

// File: rtl/booth_seq_fifo.sv
// booth_seq_fifo: operand-pair FIFO feeding the job sequencer.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push, wdata - write request and payload (accepted only when ready)
//   pop         - remove the head entry (ignored when empty)
//   head_c      - current head entry (combinational read of storage)
//   nonempty_c  - at least one entry stored
//   ready       - registered, high when level < DEPTH (no full-cycle bypass)
//   level       - current occupancy, 0..DEPTH
module booth_seq_fifo
  import booth_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  op_pair_t               wdata,
  input  logic                   pop,
  output op_pair_t               head_c,
  output logic                   nonempty_c,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  op_pair_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_d;
  logic             push_ok;
  logic             pop_ok;

  assign nonempty_c = (level != '0);
  assign head_c     = mem[rd_ptr];
  assign push_ok    = push && ready;
  assign pop_ok     = pop && nonempty_c;

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level;
    if (push_ok && !pop_ok) begin
      level_d = level + LVL_W'(1);
    end else if (!push_ok && pop_ok) begin
      level_d = level - LVL_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_d;
      ready <= (level_d < LVL_W'(DEPTH));
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/booth_job_sequencer.sv
// booth_job_sequencer: queues operand pairs and runs them one at a time
// through an external booth_multiplier, returning products in order.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   op_valid/op_ready, op_a, op_b     - operand-pair input handshake
//   mul_multiplicand, mul_multiplier  - operands held for the multiplier
//   mul_start, mul_busy, mul_p        - multiplier control and product
//   res_valid/res_ready, res_data,
//   res_err                           - result handshake (err = busy timeout)
//   fifo_level                        - operand FIFO occupancy
// Build option: define BOOTH_SEQ_ZERO_BYPASS_EN to answer jobs with a zero
// operand directly (result 0) without invoking the multiplier.
module booth_job_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [OP_W-1:0]        op_a,
  input  logic [OP_W-1:0]        op_b,
  output logic [OP_W-1:0]        mul_multiplicand,
  output logic [OP_W-1:0]        mul_multiplier,
  output logic                   mul_start,
  input  logic                   mul_busy,
  input  logic [PROD_W-1:0]      mul_p,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [PROD_W-1:0]      res_data,
  output logic                   res_err,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_q;
  state_t             state_d;
  op_pair_t           push_data;
  op_pair_t           head_c;
  logic               nonempty_c;
  logic               pop;
  logic               zero_job_c;
  logic               timeout_c;
  logic [CNT_W-1:0]   wait_cnt;

  logic               start_d;
  logic               valid_d;
  logic               err_d;
  logic [PROD_W-1:0]  data_d;
  logic [OP_W-1:0]    mcand_d;
  logic [OP_W-1:0]    mplier_d;

  assign push_data = {op_a, op_b};

  booth_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (op_valid),
    .wdata      (push_data),
    .pop        (pop),
    .head_c     (head_c),
    .nonempty_c (nonempty_c),
    .ready      (op_ready),
    .level      (fifo_level)
  );

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
  assign zero_job_c = is_zero_job(head_c);
`else
  assign zero_job_c = 1'b0;
`endif

  // Last WAIT_BUSY cycle: TIMEOUT cycles have passed since mul_start.
  assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; pop is issued only from IDLE with a non-empty FIFO.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nonempty_c) begin
          pop     = 1'b1;
          state_d = zero_job_c ? S_HOLD : S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (mul_busy)       state_d = S_RUN;
        else if (timeout_c) state_d = S_HOLD;
      end
      S_RUN:       if (!mul_busy) state_d = S_HOLD;
      S_HOLD:      if (res_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    start_d  = (state_d == S_LAUNCH);
    valid_d  = (state_d == S_HOLD);
    mcand_d  = mul_multiplicand;
    mplier_d = mul_multiplier;
    data_d   = res_data;
    err_d    = res_err;
    case (state_q)
      S_IDLE: begin
        if (nonempty_c) begin
          if (zero_job_c) begin
            data_d = '0;
            err_d  = 1'b0;
          end else begin
            mcand_d  = head_c.a;
            mplier_d = head_c.b;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (!mul_busy && timeout_c) begin
          data_d = '0;
          err_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (!mul_busy) begin
          data_d = mul_p;
          err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers; operands only change on a pop, so they stay put
  // from LAUNCH until RUN is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      res_err          <= 1'b0;
    end else begin
      mul_start        <= start_d;
      mul_multiplicand <= mcand_d;
      mul_multiplier   <= mplier_d;
      res_valid        <= valid_d;
      res_data         <= data_d;
      res_err          <= err_d;
    end
  end

  // Cycles spent waiting for mul_busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         wait_cnt <= '0;
    else if (state_q == S_WAIT_BUSY) wait_cnt <= wait_cnt + CNT_W'(1);
    else                             wait_cnt <= '0;
  end

endmodule

// File: doc/booth_job_sequencer.md
BOOTH_JOB_SEQUENCER -- requirements
Module: booth_job_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles from mul_start to mul_busy high.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports op_valid in 1, op_ready out 1: operand-pair handshake.
REQ-006 SHALL have ports op_a in 4 (multiplicand) and op_b in 4 (multiplier), two's complement.
REQ-007 SHALL have ports mul_multiplicand out 4 and mul_multiplier out 4: operands to booth_multiplier.
REQ-008 SHALL have ports mul_start out 1, mul_busy in 1, mul_p in 9: booth_multiplier control and product.
REQ-009 SHALL have ports res_valid out 1, res_ready in 1, res_data out 9, res_err out 1: result handshake.
REQ-010 SHALL have port fifo_level out $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-011 SHALL push {op_a,op_b} when op_valid&&op_ready; op_ready = (fifo_level<DEPTH), no full-cycle bypass.
REQ-012 SHALL run FSM states IDLE, LAUNCH, WAIT_BUSY, RUN, HOLD.
REQ-013 IDLE: FIFO non-empty -> pop head into mul_multiplicand/mul_multiplier, go LAUNCH next cycle.
REQ-014 LAUNCH: mul_start=1 for exactly this one cycle; -> WAIT_BUSY.
REQ-015 WAIT_BUSY: mul_busy=1 -> RUN; TIMEOUT cycles elapsed without busy -> HOLD, res_data=0, res_err=1.
REQ-016 RUN: first cycle mul_busy=0 -> capture mul_p into res_data, res_err=0, -> HOLD.
REQ-017 HOLD: res_valid=1, res_data/res_err stable; res_valid&&res_ready -> IDLE (pop allowed next cycle).
REQ-018 SHALL hold mul_multiplicand/mul_multiplier constant from LAUNCH through exit of RUN.
REQ-019 Simultaneous push and pop SHALL leave fifo_level unchanged; FIFO pointers wrap modulo DEPTH.
REQ-020 Push while full SHALL be impossible (op_ready=0); pop while empty SHALL not occur (IDLE waits).
REQ-021 Results SHALL be returned in acceptance order, one job in flight.
REQ-022 Uncontended latency: push in cycle 0 -> start in cycle 2 -> res_valid one cycle after busy falls.

Reset
REQ-023 rst SHALL asynchronously force IDLE, empty FIFO, fifo_level=0, op_ready=0 while asserted then 1.
REQ-024 On reset, mul_start=0, mul_multiplicand=0, mul_multiplier=0, res_valid=0, res_data=0, res_err=0.
REQ-025 Reset mid-job SHALL discard the in-flight job and all queued operands; no result emitted.

Configuration
REQ-026 Macro BOOTH_SEQ_ZERO_BYPASS_EN defined: popped job with op_a==0 or op_b==0 SHALL skip LAUNCH/WAIT_BUSY/RUN, go IDLE->HOLD with res_data=0, res_err=0, mul_start never pulsed.
REQ-027 Macro undefined: every job SHALL go through booth_multiplier per REQ-013..016.

Structure
REQ-028 Package booth_pkg SHALL hold operand width (4), product width (9), and FSM state enum.
REQ-029 FIFO SHALL be sub-module booth_seq_fifo (DEPTH param, push/pop/level, async reset).

Verification
REQ-030 op 3,7 with model multiplier -> one mul_start pulse, res_data=21, res_err=0.
REQ-031 Push 5 jobs with res_ready=0, DEPTH=4 -> op_ready=0 at level 4, no push lost, order preserved on release.
REQ-032 op -4,3 -> res_data=-12 (9-bit 0x1F4), res_err=0.
REQ-033 Model never raises busy -> after 16 cycles res_valid=1, res_data=0, res_err=1, next job proceeds.
REQ-034 rst asserted during RUN with 2 queued -> all outputs reset, fifo_level=0, no res_valid afterwards.
REQ-035 BOOTH_SEQ_ZERO_BYPASS_EN, op 0,6 -> res_data=0 without mul_start; undefined -> mul_start pulses, res_data=0.
